thread_scheduler: RTL and testbench



---
 rtl/thread_scheduler_pkg.sv | 30 +++
 rtl/thread_scheduler_rr_arbiter.sv | 29 ++
 rtl/thread_scheduler.sv | 140 ++++++++++++++
 tb/tb_thread_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// Shared pipeline constants for the multithreaded core: thread/register
// addressing widths and the base opcode values used by decode.
package thread_scheduler_pkg;

    localparam int THREAD_INDEX_BITS   = 3;
    localparam int NUM_THREADS         = 2 ** THREAD_INDEX_BITS;
    localparam int REG_INDEX_BITS      = 5;
    localparam int COUNT_WIDTH_DEFAULT = 32;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LOAD     = 7'b0000011;
    localparam opcode_t OPC_MISC_MEM = 7'b0001111;
    localparam opcode_t OPC_OP_IMM   = 7'b0010011;
    localparam opcode_t OPC_AUIPC    = 7'b0010111;
    localparam opcode_t OPC_STORE    = 7'b0100011;
    localparam opcode_t OPC_OP       = 7'b0110011;
    localparam opcode_t OPC_LUI      = 7'b0110111;
    localparam opcode_t OPC_BRANCH   = 7'b1100011;
    localparam opcode_t OPC_JALR     = 7'b1100111;
    localparam opcode_t OPC_JAL      = 7'b1101111;
    localparam opcode_t OPC_SYSTEM   = 7'b1110011;

    // Register file address is {thread, reg}, so threads never alias.
    typedef struct packed {
        logic [THREAD_INDEX_BITS-1:0] thread;
        logic [REG_INDEX_BITS-1:0]    reg_idx;
    } thread_reg_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after last+1,
// wrapping, reported as a valid flag plus an index.
module rr_arbiter #(
    parameter int  N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] in_request,
    input  logic [W-1:0] in_last,
    output logic         out_grant_valid,
    output logic [W-1:0] out_grant_index
);

    logic [W-1:0] cand;

    // Scan farthest-to-nearest so the nearest hit is written last.
    always_comb begin
        out_grant_valid = 1'b0;
        out_grant_index = in_last;
        cand            = '0;
        for (int i = N; i >= 1; i--) begin
            cand = W'((int'(in_last) + i) % N);
            if (in_request[cand]) begin
                out_grant_valid = 1'b1;
                out_grant_index = cand;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin thread issue scheduler with a one-in-flight-per-thread
// scoreboard. Optional counters: THREAD_SCHEDULER_PERF_COUNTERS_EN.
module thread_scheduler #(
    parameter int  THREAD_INDEX_BITS = thread_scheduler_pkg::THREAD_INDEX_BITS,
    parameter int  COUNT_WIDTH       = thread_scheduler_pkg::COUNT_WIDTH_DEFAULT,
    localparam int NUM_THREADS       = 2 ** THREAD_INDEX_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_THREADS-1:0]       in_thread_enable_mask,
    input  logic                         in_issue_ready,
    output logic                         out_issue_valid,
    output logic [THREAD_INDEX_BITS-1:0] out_issue_thread_index,
    input  logic                         in_retire_flag,
    input  logic [THREAD_INDEX_BITS-1:0] in_retire_thread_index,
    output logic [NUM_THREADS-1:0]       out_in_flight_mask,
    output logic                         out_idle
`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
    ,
    output logic [COUNT_WIDTH-1:0]       out_issue_count,
    output logic [COUNT_WIDTH-1:0]       out_stall_count,
    output logic [COUNT_WIDTH-1:0]       out_idle_count
`endif
);

    if (COUNT_WIDTH < 1 || THREAD_INDEX_BITS < 1) begin : g_bad_param
        $error("thread_scheduler: widths must be positive");
    end

    logic [NUM_THREADS-1:0]       in_flight_q, in_flight_d;
    logic                         issue_valid_q, issue_valid_d;
    logic [THREAD_INDEX_BITS-1:0] issue_index_q, issue_index_d;
    logic [THREAD_INDEX_BITS-1:0] last_q, last_d;
    logic                         idle_q, idle_d;

    logic                         handshake;
    logic [NUM_THREADS-1:0]       issue_onehot;
    logic [NUM_THREADS-1:0]       retire_onehot;
    logic [NUM_THREADS-1:0]       elig;
    logic                         gnt_valid;
    logic [THREAD_INDEX_BITS-1:0] gnt_index;

    // Retires of threads not in flight (stale after reset) are dropped.
    always_comb begin
        handshake    = issue_valid_q & in_issue_ready;
        issue_onehot = '0;
        if (handshake) begin
            issue_onehot[issue_index_q] = 1'b1;
        end
        retire_onehot = '0;
        if (in_retire_flag) begin
            retire_onehot[in_retire_thread_index] = 1'b1;
        end
        retire_onehot = retire_onehot & in_flight_q;
        in_flight_d   = (in_flight_q | issue_onehot) & ~retire_onehot;
        elig          = in_thread_enable_mask & ~in_flight_d;
    end

    rr_arbiter #(
        .N (NUM_THREADS)
    ) u_rr_arbiter (
        .in_request      (elig),
        .in_last         (last_q),
        .out_grant_valid (gnt_valid),
        .out_grant_index (gnt_index)
    );

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        last_d        = last_q;
        if (!issue_valid_q || in_issue_ready) begin
            issue_valid_d = gnt_valid;
            if (gnt_valid) begin
                issue_index_d = gnt_index;
                last_d        = gnt_index;
            end
        end
        idle_d = !issue_valid_d && (elig == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q   <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            last_q        <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
            idle_q        <= 1'b1;
        end else begin
            in_flight_q   <= in_flight_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            last_q        <= last_d;
            idle_q        <= idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_retire_flag) begin
            assert (in_flight_q[in_retire_thread_index])
            else $warning("thread_scheduler: retire of idle thread %0d",
                          in_retire_thread_index);
        end
    end

    assign out_issue_valid        = issue_valid_q;
    assign out_issue_thread_index = issue_index_q;
    assign out_in_flight_mask     = in_flight_q;
    assign out_idle               = idle_q;

`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
    logic [COUNT_WIDTH-1:0] issue_count_q, issue_count_d;
    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [COUNT_WIDTH-1:0] idle_count_q, idle_count_d;

    always_comb begin
        issue_count_d = issue_count_q + COUNT_WIDTH'(handshake);
        stall_count_d = stall_count_q
                      + COUNT_WIDTH'(issue_valid_q & ~in_issue_ready);
        idle_count_d  = idle_count_q + COUNT_WIDTH'(~issue_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count_q <= '0;
            stall_count_q <= '0;
            idle_count_q  <= '0;
        end else begin
            issue_count_q <= issue_count_d;
            stall_count_q <= stall_count_d;
            idle_count_q  <= idle_count_d;
        end
    end

    assign out_issue_count = issue_count_q;
    assign out_stall_count = stall_count_q;
    assign out_idle_count  = idle_count_q;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: vector table, hand sequences and a
// randomized run against a behavioural model of the issue rules.
module tb_thread_scheduler;

    localparam int NT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_thread_enable_mask;
    logic       in_issue_ready;
    logic       out_issue_valid;
    logic [2:0] out_issue_thread_index;
    logic       in_retire_flag;
    logic [2:0] in_retire_thread_index;
    logic [7:0] out_in_flight_mask;
    logic       out_idle;
`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
    logic [31:0] out_issue_count;
    logic [31:0] out_stall_count;
    logic [31:0] out_idle_count;
`endif

    thread_scheduler dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_thread_enable_mask  (in_thread_enable_mask),
        .in_issue_ready         (in_issue_ready),
        .out_issue_valid        (out_issue_valid),
        .out_issue_thread_index (out_issue_thread_index),
        .in_retire_flag         (in_retire_flag),
        .in_retire_thread_index (in_retire_thread_index),
        .out_in_flight_mask     (out_in_flight_mask),
        .out_idle               (out_idle)
`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
        ,
        .out_issue_count        (out_issue_count),
        .out_stall_count        (out_stall_count),
        .out_idle_count         (out_idle_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input logic [7:0] mask, input bit rdy,
                       input bit rf, input logic [2:0] ri);
        rst                    = r;
        in_thread_enable_mask  = mask;
        in_issue_ready         = rdy;
        in_retire_flag         = rf;
        in_retire_thread_index = ri;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: set of busy threads, a rotating pointer, an offer.
    bit m_busy [NT];
    int m_last;
    int m_idx;
    bit m_v;
    bit m_idle;
    int m_nissue, m_nstall, m_nidle;

    task automatic model_step(input bit r, input logic [7:0] mask,
                              input bit rdy, input bit rf, input int ri);
        bit was_busy;
        bit any;
        int pick;
        if (r) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_v = 0; m_idx = 0; m_idle = 1; m_last = NT - 1;
            m_nissue = 0; m_nstall = 0; m_nidle = 0;
            return;
        end
        if (m_v && rdy) m_nissue++;
        if (m_v && !rdy) m_nstall++;
        if (!m_v) m_nidle++;
        was_busy = rf && m_busy[ri];
        if (m_v && rdy) m_busy[m_idx] = 1;
        if (was_busy) m_busy[ri] = 0;
        any = 0;
        for (int t = 0; t < NT; t++)
            if (mask[t] && !m_busy[t]) any = 1;
        if (!m_v || rdy) begin
            pick = -1;
            for (int k = 1; k <= NT; k++) begin
                int t;
                t = (m_last + k) % NT;
                if (pick < 0 && mask[t] && !m_busy[t]) pick = t;
            end
            m_v = (pick >= 0);
            if (pick >= 0) begin
                m_idx = pick;
                m_last = pick;
            end
        end
        m_idle = !m_v && !any;
    endtask

    function automatic logic [7:0] model_mask();
        logic [7:0] m;
        m = '0;
        for (int t = 0; t < NT; t++) m[t] = m_busy[t];
        return m;
    endfunction

    typedef struct {
        bit         r;
        logic [7:0] mask;
        bit         rdy;
        bit         rf;
        logic [2:0] ri;
        bit         ev;
        logic [2:0] ei;
        logic [7:0] em;
        bit         eidle;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int k;
        logic [7:0] rmask;
        bit rdy, r, rf;
        int ri;
        int busy_list[$];

        rst = 1; in_thread_enable_mask = 0; in_issue_ready = 0;
        in_retire_flag = 0; in_retire_thread_index = 0;

        // Full mask, retire 5 issues later: strict 0..7 rotation.
        cyc(1, 8'h00, 0, 0, 0);
        cyc(1, 8'hFF, 1, 0, 0);
        chk("reset_valid", 32'(out_issue_valid), 0);
        chk("reset_index", 32'(out_issue_thread_index), 0);
        chk("reset_mask", 32'(out_in_flight_mask), 0);
        chk("reset_idle", 32'(out_idle), 1);
        for (k = 0; k < 24; k++) begin
            if (k >= 6) cyc(0, 8'hFF, 1, 1, 3'((k - 6) % 8));
            else cyc(0, 8'hFF, 1, 0, 0);
            chk("rr_valid", 32'(out_issue_valid), 1);
            chk("rr_index", 32'(out_issue_thread_index), 32'(k % 8));
            chk("rr_busy_cnt", 32'($countones(out_in_flight_mask)),
                32'((k < 5) ? k : 5));
        end

        // r mask rdy rf ri | valid idx busy idle
        tbl.push_back('{1, 8'h05, 1, 0, 0, 0, 0, 8'h00, 1});
        tbl.push_back('{0, 8'h05, 1, 0, 0, 1, 0, 8'h00, 0});
        tbl.push_back('{0, 8'h05, 1, 0, 0, 1, 2, 8'h01, 0});
        tbl.push_back('{0, 8'h05, 1, 0, 0, 0, 2, 8'h05, 1});
        tbl.push_back('{0, 8'h05, 1, 0, 0, 0, 2, 8'h05, 1});
        tbl.push_back('{0, 8'h05, 1, 1, 2, 1, 2, 8'h01, 0});
        tbl.push_back('{0, 8'h05, 0, 1, 0, 1, 2, 8'h00, 0});
        tbl.push_back('{0, 8'h05, 1, 0, 0, 1, 0, 8'h04, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 8'h05, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 6, 0, 0, 8'h05, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 8'h04, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 2, 0, 0, 8'h00, 1});
        tbl.push_back('{0, 8'h08, 0, 0, 0, 1, 3, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 1, 3, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 1, 3, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 1, 3, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 3, 8'h08, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 3, 0, 3, 8'h00, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 6, 0, 3, 8'h00, 1});
        tbl.push_back('{0, 8'hFF, 1, 0, 0, 1, 4, 8'h00, 0});
        tbl.push_back('{0, 8'hFF, 1, 0, 0, 1, 5, 8'h10, 0});
        tbl.push_back('{0, 8'hFF, 1, 0, 0, 1, 6, 8'h30, 0});
        tbl.push_back('{0, 8'hFF, 1, 0, 0, 1, 7, 8'h70, 0});
        tbl.push_back('{0, 8'hFF, 1, 0, 0, 1, 0, 8'hF0, 0});
        tbl.push_back('{1, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 1});
        tbl.push_back('{0, 8'hFF, 1, 1, 5, 1, 0, 8'h00, 0});
        tbl.push_back('{0, 8'hFF, 0, 1, 6, 1, 0, 8'h00, 0});
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].mask, tbl[i].rdy, tbl[i].rf, tbl[i].ri);
            chk($sformatf("vec%0d_valid", i), 32'(out_issue_valid),
                32'(tbl[i].ev));
            chk($sformatf("vec%0d_index", i),
                32'(out_issue_thread_index), 32'(tbl[i].ei));
            chk($sformatf("vec%0d_busy", i), 32'(out_in_flight_mask),
                32'(tbl[i].em));
            chk($sformatf("vec%0d_idle", i), 32'(out_idle),
                32'(tbl[i].eidle));
        end

`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
        // 2 idle cycles, 10 issues, then 3 stalled cycles.
        cyc(1, 8'h00, 1, 0, 0);
        chk("perf_reset", out_issue_count | out_stall_count
            | out_idle_count, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'hFF, 1, 0, 0);
        for (k = 2; k <= 11; k++) begin
            if (k >= 3) cyc(0, 8'hFF, 1, 1, 3'((k - 3) % 8));
            else cyc(0, 8'hFF, 1, 0, 0);
        end
        for (k = 0; k < 3; k++) cyc(0, 8'hFF, 0, 0, 0);
        chk("perf_issue", out_issue_count, 10);
        chk("perf_stall", out_stall_count, 3);
        chk("perf_idle", out_idle_count, 2);
`endif

        // Randomized run against the model.
        model_step(1, 8'h00, 0, 0, 0);
        cyc(1, 8'h00, 0, 0, 0);
        rmask = 8'hFF;
        for (k = 0; k < 1500; k++) begin
            if (k % 40 == 0) begin
                rmask = 8'($urandom);
                if ($urandom_range(3) == 0) rmask = 8'hFF;
            end
            r = ($urandom_range(99) == 0);
            rdy = ($urandom_range(3) != 0);
            rf = 0;
            ri = 0;
            busy_list.delete();
            for (int t = 0; t < NT; t++)
                if (m_busy[t]) busy_list.push_back(t);
            if (busy_list.size() > 0 && $urandom_range(1) == 1) begin
                rf = 1;
                ri = busy_list[$urandom_range(busy_list.size() - 1)];
            end else if ($urandom_range(63) == 0) begin
                rf = 1;
                ri = int'($urandom_range(NT - 1));
            end
            model_step(r, rmask, rdy, rf, ri);
            cyc(r, rmask, rdy, rf, 3'(ri));
            chk("rnd_valid", 32'(out_issue_valid), 32'(m_v));
            chk("rnd_index", 32'(out_issue_thread_index), 32'(m_idx));
            chk("rnd_busy", 32'(out_in_flight_mask), 32'(model_mask()));
            chk("rnd_idle", 32'(out_idle), 32'(m_idle));
`ifdef THREAD_SCHEDULER_PERF_COUNTERS_EN
            chk("rnd_issue_cnt", out_issue_count, 32'(m_nissue));
            chk("rnd_stall_cnt", out_stall_count, 32'(m_nstall));
            chk("rnd_idle_cnt", out_idle_count, 32'(m_nidle));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
